// File: rtl/seg7_display_driver_if.sv
// Register-side bus of the 7-segment driver: write strobe, write data and
// the latched value read back by the memory-mapped bridge.
interface seg7_display_driver_if;
   logic        seg_we;
   logic [15:0] seg_wdata;
   logic [15:0] value_q;

   modport master (output seg_we, output seg_wdata, input value_q);
   modport slave  (input seg_we, input seg_wdata, output value_q);
endinterface

// File: rtl/seg7_display_driver.sv
// Four-digit multiplexed hex display driver with anti-ghost blanking and
// optional leading-zero suppression; all outputs registered.
module seg7_display_driver #(
   parameter int DIGIT_PERIOD = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int BLANK_LZ     = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   seg7_display_driver_if.slave  seg_bus,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [3:0]            an
);

   localparam int CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

   logic [15:0]      value_q, value_d;
   logic [15:0]      disp_q, disp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [6:0]       seg_q, seg_d;
   logic [3:0]       an_q, an_d;

   logic [3:0]       nib [4];
   logic [3:0]       upper_zero;
   logic             wrap;
   logic             lz_blank;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      case (h)
         4'h0:    hex_to_seg = 7'h40;
         4'h1:    hex_to_seg = 7'h79;
         4'h2:    hex_to_seg = 7'h24;
         4'h3:    hex_to_seg = 7'h30;
         4'h4:    hex_to_seg = 7'h19;
         4'h5:    hex_to_seg = 7'h12;
         4'h6:    hex_to_seg = 7'h02;
         4'h7:    hex_to_seg = 7'h78;
         4'h8:    hex_to_seg = 7'h00;
         4'h9:    hex_to_seg = 7'h10;
         4'hA:    hex_to_seg = 7'h08;
         4'hB:    hex_to_seg = 7'h03;
         4'hC:    hex_to_seg = 7'h46;
         4'hD:    hex_to_seg = 7'h21;
         4'hE:    hex_to_seg = 7'h06;
         default: hex_to_seg = 7'h0E;
      endcase
   endfunction

   // upper_zero[k] is set when nibbles k..3 of the shadow value are all zero.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_nib
         assign nib[gi] = disp_q[4*gi +: 4];
         if (gi == 3) begin : g_top
            assign upper_zero[gi] = (nib[gi] == 4'h0);
         end else begin : g_low
            assign upper_zero[gi] = upper_zero[gi+1] & (nib[gi] == 4'h0);
         end
      end
   endgenerate

   always_comb begin
      value_d  = seg_bus.seg_we ? seg_bus.seg_wdata : value_q;
      wrap     = (cnt_q == CNT_LAST);
      cnt_d    = wrap ? '0 : cnt_q + 1'b1;
      idx_d    = wrap ? idx_q + 2'd1 : idx_q;
      // The shadow only changes between scans so a scan never mixes two values.
      disp_d   = (wrap && idx_q == 2'd3) ? value_q : disp_q;
      lz_blank = (BLANK_LZ != 0) && (idx_q != 2'd0) && upper_zero[idx_q];
      seg_d    = lz_blank ? 7'h7F : hex_to_seg(nib[idx_q]);
      an_d     = 4'b1111;
      if (!lz_blank && cnt_q >= CNT_BLANK) begin
         an_d[idx_q] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value_q <= '0;
         disp_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         seg_q   <= 7'h7F;
         an_q    <= 4'b1111;
      end else begin
         value_q <= value_d;
         disp_q  <= disp_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign seg_bus.value_q = value_q;
   assign seg             = seg_q;
   assign an              = an_q;
   assign dp              = 1'b1;

endmodule

// File: tb/tb_seg7_display_driver.sv
// Directed bench: two drivers (plain and leading-zero blanking) fed the same
// writes, checked cycle by cycle against hand-computed segment/anode values.
module tb_seg7_display_driver;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   seg7_display_driver_if bus_a ();
   seg7_display_driver_if bus_b ();

   logic [6:0] seg_a, seg_b;
   logic       dp_a, dp_b;
   logic [3:0] an_a, an_b;

   seg7_display_driver #(.DIGIT_PERIOD(8), .BLANK_CYCLES(2), .BLANK_LZ(0)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .seg_bus (bus_a),
      .seg     (seg_a),
      .dp      (dp_a),
      .an      (an_a)
   );

   seg7_display_driver #(.DIGIT_PERIOD(8), .BLANK_CYCLES(2), .BLANK_LZ(1)) u_dut_lz (
      .clk     (clk),
      .reset   (reset),
      .seg_bus (bus_b),
      .seg     (seg_b),
      .dp      (dp_b),
      .an      (an_b)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_val;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_we(input logic we, input logic [15:0] d);
      bus_a.seg_we    = we;
      bus_a.seg_wdata = d;
      bus_b.seg_we    = we;
      bus_b.seg_wdata = d;
   endtask

   // One 8-cycle digit slot; optional write(s) issued at cycle wr_at (and wr_at+1).
   task automatic check_slot(input string tag, input int k,
                             input logic [6:0] seg_x, input bit lit_b,
                             input int wr_at, input int wr_n,
                             input logic [15:0] wd0, input logic [15:0] wd1);
      logic [3:0] an_x;
      an_x    = 4'b1111;
      an_x[k] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         if (bus_a.seg_we) exp_val = bus_a.seg_wdata;
         @(negedge clk);
         drive_we(1'b0, 16'h0000);
         check($sformatf("%s d%0d c%0d value_a", tag, k, i), bus_a.value_q, exp_val);
         check($sformatf("%s d%0d c%0d value_b", tag, k, i), bus_b.value_q, exp_val);
         if (i < 2) begin
            check($sformatf("%s d%0d c%0d an_a blank", tag, k, i), an_a, 4'b1111);
            check($sformatf("%s d%0d c%0d an_b blank", tag, k, i), an_b, 4'b1111);
         end else begin
            check($sformatf("%s d%0d c%0d an_a", tag, k, i), an_a, an_x);
            check($sformatf("%s d%0d c%0d seg_a", tag, k, i), seg_a, seg_x);
            check($sformatf("%s d%0d c%0d an_b", tag, k, i), an_b, lit_b ? an_x : 4'b1111);
            check($sformatf("%s d%0d c%0d seg_b", tag, k, i), seg_b, lit_b ? seg_x : 7'h7F);
         end
         if (wr_n > 0 && i == wr_at)     drive_we(1'b1, wd0);
         if (wr_n > 1 && i == wr_at + 1) drive_we(1'b1, wd1);
      end
   endtask

   // segs packs expected cathodes {d3,d2,d1,d0}; lit_b marks digits lit on the blanking driver.
   task automatic run_scan(input string tag, input logic [27:0] segs, input logic [3:0] lit_b,
                           input int wr_slot, input int wr_at, input int wr_n,
                           input logic [15:0] wd0, input logic [15:0] wd1);
      for (int k = 0; k < 4; k++) begin
         check_slot(tag, k, segs[k*7 +: 7], lit_b[k], (k == wr_slot) ? wr_at : -1, wr_n, wd0, wd1);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " an_a"},    an_a,          4'b1111);
      check({tag, " seg_a"},   seg_a,         7'h7F);
      check({tag, " dp_a"},    dp_a,          1'b1);
      check({tag, " value_a"}, bus_a.value_q, 16'h0000);
      check({tag, " an_b"},    an_b,          4'b1111);
      check({tag, " seg_b"},   seg_b,         7'h7F);
      check({tag, " dp_b"},    dp_b,          1'b1);
      check({tag, " value_b"}, bus_b.value_q, 16'h0000);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b0;
      exp_val = 16'h0000;
      drive_we(1'b0, 16'h0000);
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");

      // A write strobed while reset is held must be discarded.
      drive_we(1'b1, 16'hBEEF);
      @(negedge clk);
      check_reset_outputs("reset_we");
      drive_we(1'b0, 16'h0000);
      reset = 1'b1;

      run_scan("scan0", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0001, 0, 3, 1, 16'h1A2F, 16'h0000);
      run_scan("scan1", {7'h79, 7'h08, 7'h24, 7'h0E}, 4'b1111, 1, 2, 2, 16'h1234, 16'h5678);
      run_scan("scan2", {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1111, 2, 0, 1, 16'h0003, 16'h0000);
      run_scan("scan3", {7'h40, 7'h40, 7'h40, 7'h30}, 4'b0001, 3, 1, 1, 16'hFFFF, 16'h0000);

      check_slot("scan4", 0, 7'h0E, 1'b1, -1, 0, 16'h0000, 16'h0000);
      check_slot("scan4", 1, 7'h0E, 1'b1, -1, 0, 16'h0000, 16'h0000);
      repeat (5) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      exp_val = 16'h0000;
      check_reset_outputs("async_reset");
      repeat (2) @(negedge clk);
      check_reset_outputs("async_reset_held");
      reset = 1'b1;

      run_scan("post_reset", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0001, -1, -1, 0, 16'h0000, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_display_driver.md
SEG7_DISPLAY_DRIVER -- requirements
Module: seg7_display_driver

Interface
REQ-001 SHALL have parameter DIGIT_PERIOD, default 100000, clk cycles per digit slot (1 ms at 100 MHz); legal range 4 and up.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000, anode-off cycles at the start of each slot (anti-ghosting); legal range below DIGIT_PERIOD.
REQ-003 SHALL have parameter BLANK_LZ, default 0; when 1, leading-zero blanking is enabled.
REQ-004 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port seg_we  in  1  write strobe from memory_io_bridge 7-seg register.
REQ-007 SHALL have port seg_wdata  in  16  value to display, four hex nibbles.
REQ-008 SHALL have port value_q  out  16  currently latched value, for bridge readback.
REQ-009 SHALL have port seg  out  7  cathodes, active-low, seg[0]=a through seg[6]=g.
REQ-010 SHALL have port dp  out  1  decimal point, active-low, held 1 (off).
REQ-011 SHALL have port an  out  4  anodes, active-low, an[0]=rightmost digit.

Function
REQ-012 SHALL load value_q <= seg_wdata on each rising clk with seg_we=1; value_q is visible 1 cycle after the strobe edge.
REQ-013 SHALL hold value_q when seg_we=0; back-to-back strobes SHALL each load, and the last one wins.
REQ-014 SHALL keep a shadow register disp_q, loaded from value_q only when the slot counter wraps from digit 3 to digit 0, so that one scan never mixes two values.
REQ-015 SHALL run slot counter cnt 0..DIGIT_PERIOD-1, then wrap to 0 and advance digit index idx 0->1->2->3->0.
REQ-016 SHALL drive idx=k to select nibble disp_q[4k+3:4k] and assert an[k]=0, with the other anodes at 1.
REQ-017 SHALL drive an=4'b1111 while cnt < BLANK_CYCLES, regardless of idx.
REQ-018 SHALL register seg and an, with outputs reflecting cnt/idx of the previous cycle (1-cycle latency).
REQ-019 SHALL decode hex active-low gfedcba as follows: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-020 SHALL, when BLANK_LZ=1, blank digit k (an[k]=1, seg=7F) if all nibbles k..3 of disp_q are zero and k>0; digit 0 always shows, so value 0 shows a single "0".
REQ-021 SHALL leave the scan unaffected by seg_we; a write never resets cnt or idx.
REQ-022 SHALL contain no combinational path from seg_we or seg_wdata to seg or an.

Reset
REQ-023 SHALL, while reset=0, asynchronously force value_q=0, disp_q=0, cnt=0, idx=0, an=1111, seg=7F, dp=1.
REQ-024 SHALL, on reset deassertion, start with digit 0 slot and BLANK_CYCLES of blanking before any anode is driven.
REQ-025 SHALL, on reset asserted mid-slot or mid-write, abandon the operation immediately, and the pending write is lost.

Verification (DIGIT_PERIOD=8, BLANK_CYCLES=2 unless noted)
REQ-026 Reset, no writes -> an=1110 after 2 blank cycles, seg=40 ("0"); anodes rotate 1110, 1101, 1011, 0111 every 8 cycles, each slot starting with 2 cycles of an=1111.
REQ-027 Write 16'h1A2F at idle -> value_q=1A2F next cycle; from the next digit-0 slot, digits 0..3 show seg 0E, 24, 08, 79.
REQ-028 Write 16'h1234 then 16'h5678 mid-scan (during idx=1) -> the current scan completes with the old disp_q; the next scan shows only 5678 with no mixed digits; value_q=5678.
REQ-029 BLANK_LZ=1, write 16'h0003 -> digit 0 seg=30, digits 1..3 an stays 1 for the entire slot; write 0 -> only digit 0 lit with seg=40.
REQ-030 Assert reset during idx=2, cnt=5 after writing FFFF -> outputs go to the reset values within the same cycle without a clock edge; value_q=0 and the display shows 0000 after release.
REQ-031 Default parameters at 100 MHz -> a full 4-digit scan takes 400000 cycles (4 ms, 250 Hz refresh); check cnt wrap at 99999.
